// File: rtl/fsm_table_sequencer_if.sv
// Control, config and status bundle for the table-driven FSM sequencer.
// master drives the run/config inputs; slave is the sequencer itself.
interface fsm_table_sequencer_if #(
  parameter int unsigned CNT_W = 8
);
  logic             cfg_we;
  logic [3:0]       cfg_addr;
  logic [5:0]       cfg_data;
  logic             start;
  logic             stop;
  logic             a;
  logic [2:0]       init_state;
  logic [2:0]       target;
  logic             target_en;
  logic [CNT_W-1:0] max_steps;
  logic [2:0]       estado;
  logic [2:0]       saida;
  logic [CNT_W-1:0] step_cnt;
  logic             busy;
  logic             done;
  logic             hit;
  logic             cfg_err;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, stop, a,
           init_state, target, target_en, max_steps,
    input  estado, saida, step_cnt, busy, done, hit, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, stop, a,
           init_state, target, target_en, max_steps,
    output estado, saida, step_cnt, busy, done, hit, cfg_err
  );
endinterface

// File: rtl/fsm_table_sequencer.sv
// Table-driven 3-bit-state / 1-input FSM engine with run control,
// step limiting and target-state detection around a 16x6 runtime table.
module fsm_table_sequencer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  fsm_table_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [5:0]       r_table [16];
  logic [2:0]       r_estado, w_estado_nxt;
  logic [2:0]       r_saida, w_saida_nxt;
  logic [CNT_W-1:0] r_step_cnt, w_cnt_nxt, w_cnt_inc;
  logic             r_hit, w_hit_nxt;
  logic             r_cfg_err, w_cfg_err_nxt;
  logic             r_busy, r_done;
  logic [5:0]       w_entry;
  logic             w_tgt, w_lim, w_sat;

  // Table storage survives reset; writes only land while idle.
  always_ff @(posedge clk) begin
    if (bus.cfg_we && (r_state == ST_IDLE)) begin
      r_table[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  assign w_entry   = r_table[{r_estado, bus.a}];
  assign w_cnt_inc = r_step_cnt + CNT_W'(1);
  assign w_sat     = (bus.max_steps == '0) && (&r_step_cnt);
  assign w_tgt     = bus.target_en && (w_entry[5:3] == bus.target);
  assign w_lim     = (bus.max_steps != '0) && (w_cnt_inc == bus.max_steps);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_estado   <= 3'd0;
      r_saida    <= 3'd0;
      r_step_cnt <= '0;
      r_hit      <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_estado   <= w_estado_nxt;
      r_saida    <= w_saida_nxt;
      r_step_cnt <= w_cnt_nxt;
      r_hit      <= w_hit_nxt;
      r_cfg_err  <= w_cfg_err_nxt;
      r_busy     <= (w_state_nxt == ST_RUN);
      r_done     <= (w_state_nxt == ST_DONE);
    end
  end

  // Stop outranks everything in RUN and DONE; target outranks the step limit.
  always_comb begin
    w_state_nxt   = r_state;
    w_estado_nxt  = r_estado;
    w_saida_nxt   = r_saida;
    w_cnt_nxt     = r_step_cnt;
    w_hit_nxt     = r_hit;
    w_cfg_err_nxt = bus.cfg_we && (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt  = ST_RUN;
          w_estado_nxt = bus.init_state;
          w_cnt_nxt    = '0;
          w_hit_nxt    = 1'b0;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_estado_nxt = w_entry[5:3];
          w_saida_nxt  = w_entry[2:0];
          w_cnt_nxt    = w_sat ? r_step_cnt : w_cnt_inc;
          if (w_tgt) begin
            w_state_nxt = ST_DONE;
            w_hit_nxt   = 1'b1;
          end else if (w_lim) begin
            w_state_nxt = ST_DONE;
            w_hit_nxt   = 1'b0;
          end
        end
      end
      ST_DONE: begin
        if (bus.stop) begin
          w_state_nxt = ST_IDLE;
          w_hit_nxt   = 1'b0;
        end else if (bus.start) begin
          w_state_nxt  = ST_RUN;
          w_estado_nxt = bus.init_state;
          w_cnt_nxt    = '0;
          w_hit_nxt    = 1'b0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.estado   = r_estado;
  assign bus.saida    = r_saida;
  assign bus.step_cnt = r_step_cnt;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.hit      = r_hit;
  assign bus.cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_fsm_table_sequencer.sv
// Directed-vector bench for fsm_table_sequencer using the digit-sequence table.
module tb_fsm_table_sequencer;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  fsm_table_sequencer_if #(.CNT_W(8)) bus ();

  fsm_table_sequencer #(.CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] addr, input logic [5:0] data);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = addr;
    bus.cfg_data = data;
    tick();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  task automatic chk_step(input string tag, input logic [2:0] est, input logic [2:0] sai);
    chk({tag, "_estado"}, 32'(bus.estado), 32'(est));
    chk({tag, "_saida"},  32'(bus.saida),  32'(sai));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_estado"},  32'(bus.estado),   0);
    chk({tag, "_saida"},   32'(bus.saida),    0);
    chk({tag, "_cnt"},     32'(bus.step_cnt), 0);
    chk({tag, "_busy"},    32'(bus.busy),     0);
    chk({tag, "_done"},    32'(bus.done),     0);
    chk({tag, "_hit"},     32'(bus.hit),      0);
    chk({tag, "_cfg_err"}, 32'(bus.cfg_err),  0);
  endtask

  // Init 010, a=0, target 000: 100/0, 110/3, 000/2 then DONE with hit.
  task automatic run_digit(input string tag);
    bus.init_state = 3'b010;
    bus.a          = 1'b0;
    bus.target     = 3'b000;
    bus.target_en  = 1'b1;
    bus.max_steps  = 8'd0;
    pulse_start();
    chk({tag, "_busy0"}, 32'(bus.busy), 1);
    chk({tag, "_cnt0"},  32'(bus.step_cnt), 0);
    chk({tag, "_init"},  32'(bus.estado), 32'(3'b010));
    tick(); chk_step({tag, "_s1"}, 3'b100, 3'd0);
    tick(); chk_step({tag, "_s2"}, 3'b110, 3'd3);
    chk({tag, "_done_early"}, 32'(bus.done), 0);
    tick(); chk_step({tag, "_s3"}, 3'b000, 3'd2);
    chk({tag, "_done"}, 32'(bus.done), 1);
    chk({tag, "_hit"},  32'(bus.hit), 1);
    chk({tag, "_cnt"},  32'(bus.step_cnt), 3);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    pulse_stop();
    chk({tag, "_idle_done"}, 32'(bus.done), 0);
    chk({tag, "_idle_hit"},  32'(bus.hit), 0);
  endtask

  initial begin
    logic [2:0] exp_est [5];
    logic [2:0] exp_sai [5];
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_addr = 4'd0; bus.cfg_data = 6'd0;
    bus.start = 1'b0;  bus.stop = 1'b0;     bus.a = 1'b0;
    bus.init_state = 3'd0; bus.target = 3'd0; bus.target_en = 1'b0;
    bus.max_steps = 8'd0;
    tick(); tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();

    load(4'd0, 6'h14);  load(4'd1, 6'h24);  load(4'd2, 6'h35);
    load(4'd3, 6'h35);  load(4'd4, 6'h20);  load(4'd5, 6'h20);
    load(4'd8, 6'h33);  load(4'd9, 6'h0b);  load(4'd12, 6'h02);
    load(4'd13, 6'h02);

    run_digit("t1");

    // Step limit of 5 with target detection off.
    exp_est = '{3'b100, 3'b110, 3'b000, 3'b010, 3'b100};
    exp_sai = '{3'd0, 3'd3, 3'd2, 3'd4, 3'd0};
    bus.target_en = 1'b0;
    bus.max_steps = 8'd5;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_step($sformatf("t2_s%0d", i + 1), exp_est[i], exp_sai[i]);
      if (i == 3) chk("t2_done_early", 32'(bus.done), 0);
    end
    chk("t2_done", 32'(bus.done), 1);
    chk("t2_hit",  32'(bus.hit), 0);
    chk("t2_cnt",  32'(bus.step_cnt), 5);
    tick();
    chk("t2_hold_est", 32'(bus.estado), 32'(3'b100));
    chk("t2_hold_cnt", 32'(bus.step_cnt), 5);
    pulse_stop();

    // Input switches to a=1 from the second step.
    bus.max_steps = 8'd3;
    bus.a = 1'b0;
    pulse_start();
    tick(); chk_step("t3_s1", 3'b100, 3'd0);
    bus.a = 1'b1;
    tick(); chk_step("t3_s2", 3'b001, 3'd3);
    tick(); chk_step("t3_s3", 3'b110, 3'd5);
    chk("t3_done", 32'(bus.done), 1);
    chk("t3_hit",  32'(bus.hit), 0);
    bus.a = 1'b0;
    pulse_stop();

    // Mid-run stop plus a rejected write during RUN.
    bus.max_steps = 8'd0;
    pulse_start();
    bus.cfg_we = 1'b1; bus.cfg_addr = 4'd4; bus.cfg_data = 6'h3f;
    tick();
    bus.cfg_we = 1'b0;
    chk("t4_cfg_err", 32'(bus.cfg_err), 1);
    chk("t4_s1_est",  32'(bus.estado), 32'(3'b100));
    tick();
    chk("t4_cfg_err_clr", 32'(bus.cfg_err), 0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("t4_busy", 32'(bus.busy), 0);
    chk("t4_done", 32'(bus.done), 0);
    chk("t4_est",  32'(bus.estado), 32'(3'b110));
    chk("t4_cnt",  32'(bus.step_cnt), 2);
    run_digit("t4_rerun");

    // Reset mid-run, then the retained table reproduces the digit run.
    bus.target_en = 1'b1; bus.target = 3'b000; bus.init_state = 3'b010;
    pulse_start();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_vals("t5_rst");
    run_digit("t5_rerun");

    // Target beats limit on the same step; start in DONE restarts.
    bus.target = 3'b100; bus.target_en = 1'b1; bus.max_steps = 8'd1;
    bus.init_state = 3'b010; bus.a = 1'b0;
    pulse_start();
    tick();
    chk("t6_done", 32'(bus.done), 1);
    chk("t6_hit",  32'(bus.hit), 1);
    chk("t6_cnt",  32'(bus.step_cnt), 1);
    chk("t6_est",  32'(bus.estado), 32'(3'b100));
    pulse_start();
    chk("t6_re_busy", 32'(bus.busy), 1);
    chk("t6_re_cnt",  32'(bus.step_cnt), 0);
    chk("t6_re_est",  32'(bus.estado), 32'(3'b010));
    chk("t6_re_hit",  32'(bus.hit), 0);
    tick();
    chk("t6_re_done", 32'(bus.done), 1);
    bus.start = 1'b1; bus.stop = 1'b1;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    chk("t6_ss_busy", 32'(bus.busy), 0);
    chk("t6_ss_done", 32'(bus.done), 0);
    chk("t6_ss_hit",  32'(bus.hit), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
